// File: rtl/s3_operand_latch.sv
// s3_operand_latch: ID->EX pipeline register with operand forwarding, load-use stall and flush
// Ports:
//   clk, rst_n                     clock (rising edge), async active-low reset
//   flush                          kill held instr and any accept this cycle
//   id_valid/id_ready              decode handshake (id_ready combinational)
//   id_op, id_rs1, id_rs2, id_rd   decoded fields
//   id_rs1_data, id_rs2_data       regfile reads
//   id_imm, id_use_imm, id_pc      immediate, b-select, instruction PC
//   mem_fwd_*                      MEM stage forwarding (load flag marks data not yet valid)
//   wb_fwd_*                       WB stage forwarding
//   ex_valid/ex_ready              execute handshake
//   ex_a, ex_b, ex_rs2_val         resolved operands, rs2 kept for store data
//   ex_op, ex_rd, ex_pc            registered instruction fields
module s3_operand_latch #(
  parameter int XLEN  = 32,
  parameter int OPW   = 5,
  parameter int REGAW = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [OPW-1:0]   id_op,
  input  logic [REGAW-1:0] id_rs1,
  input  logic [REGAW-1:0] id_rs2,
  input  logic [REGAW-1:0] id_rd,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic             id_use_imm,
  input  logic [XLEN-1:0]  id_pc,
  input  logic             mem_fwd_we,
  input  logic [REGAW-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0]  mem_fwd_data,
  input  logic             mem_fwd_load,
  input  logic             wb_fwd_we,
  input  logic [REGAW-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]  wb_fwd_data,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [XLEN-1:0]  ex_a,
  output logic [XLEN-1:0]  ex_b,
  output logic [XLEN-1:0]  ex_rs2_val,
  output logic [OPW-1:0]   ex_op,
  output logic [REGAW-1:0] ex_rd,
  output logic [XLEN-1:0]  ex_pc
);
  logic             hazard, accept;
  logic [XLEN-1:0]  rs1_val, rs2_val;
  logic             valid_d, valid_q;
  logic [XLEN-1:0]  a_d, a_q, b_d, b_q, rs2_d, rs2_q, pc_d, pc_q;
  logic [OPW-1:0]   op_d, op_q;
  logic [REGAW-1:0] rd_d, rd_q;
  always_comb begin
    // a load in MEM has no data yet; only the sources actually read can stall
    hazard = id_valid & mem_fwd_we & mem_fwd_load & (mem_fwd_rd != '0) &
             ((mem_fwd_rd == id_rs1) | (~id_use_imm & (mem_fwd_rd == id_rs2)));
    id_ready = (~valid_q | ex_ready) & ~hazard;
    accept = id_valid & id_ready & ~flush;
    rs1_val = (id_rs1 == '0) ? '0 :
              (mem_fwd_we & ~mem_fwd_load & (mem_fwd_rd == id_rs1)) ? mem_fwd_data :
              (wb_fwd_we & (wb_fwd_rd == id_rs1)) ? wb_fwd_data : id_rs1_data;
    rs2_val = (id_rs2 == '0) ? '0 :
              (mem_fwd_we & ~mem_fwd_load & (mem_fwd_rd == id_rs2)) ? mem_fwd_data :
              (wb_fwd_we & (wb_fwd_rd == id_rs2)) ? wb_fwd_data : id_rs2_data;
    valid_d = flush ? 1'b0 : accept ? 1'b1 : ex_ready ? 1'b0 : valid_q;
    a_d   = accept ? rs1_val : a_q;
    b_d   = accept ? (id_use_imm ? id_imm : rs2_val) : b_q;
    rs2_d = accept ? rs2_val : rs2_q;
    op_d  = accept ? id_op : op_q;
    rd_d  = accept ? id_rd : rd_q;
    pc_d  = accept ? id_pc : pc_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rs2_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rs2_q   <= rs2_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      pc_q    <= pc_d;
    end
  end
  assign ex_valid   = valid_q;
  assign ex_a       = a_q;
  assign ex_b       = b_q;
  assign ex_rs2_val = rs2_q;
  assign ex_op      = op_q;
  assign ex_rd      = rd_q;
  assign ex_pc      = pc_q;
endmodule

// File: tb/tb_s3_operand_latch.sv
// tb_s3_operand_latch: directed stimulus, per-cycle model comparison plus literal pins
module tb_s3_operand_latch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0, id_valid = 1'b0, id_use_imm = 1'b0;
  logic        id_ready;
  logic [4:0]  id_op = '0, id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [31:0] id_rs1_data = '0, id_rs2_data = '0, id_imm = '0, id_pc = '0;
  logic        mem_fwd_we = 1'b0, mem_fwd_load = 1'b0, wb_fwd_we = 1'b0;
  logic [4:0]  mem_fwd_rd = '0, wb_fwd_rd = '0;
  logic [31:0] mem_fwd_data = '0, wb_fwd_data = '0;
  logic        ex_valid, ex_ready = 1'b1;
  logic [31:0] ex_a, ex_b, ex_rs2_val, ex_pc;
  logic [4:0]  ex_op, ex_rd;
  int tests = 0, fails = 0;

  s3_operand_latch dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_op(id_op), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_pc(id_pc),
    .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .mem_fwd_load(mem_fwd_load), .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd),
    .wb_fwd_data(wb_fwd_data), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_a(ex_a), .ex_b(ex_b), .ex_rs2_val(ex_rs2_val), .ex_op(ex_op), .ex_rd(ex_rd),
    .ex_pc(ex_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the execute stage should see, tracked from the handshake rules
  logic        m_v = 1'b0;
  logic [31:0] m_a = '0, m_b = '0, m_rs2 = '0, m_pc = '0;
  logic [4:0]  m_op = '0, m_rd = '0;

  function automatic logic [31:0] resolve(input logic [4:0] r, input logic [31:0] rf);
    if (r == 0) return 32'h0;
    if (mem_fwd_we && !mem_fwd_load && mem_fwd_rd == r) return mem_fwd_data;
    if (wb_fwd_we && wb_fwd_rd == r) return wb_fwd_data;
    return rf;
  endfunction

  function automatic logic m_ready();
    logic stall;
    stall = id_valid && mem_fwd_we && mem_fwd_load && mem_fwd_rd != 0 &&
            (mem_fwd_rd == id_rs1 || (!id_use_imm && mem_fwd_rd == id_rs2));
    return (!m_v || ex_ready) && !stall;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v <= 1'b0; m_a <= '0; m_b <= '0; m_rs2 <= '0; m_pc <= '0; m_op <= '0; m_rd <= '0;
    end else if (flush) begin
      m_v <= 1'b0;
    end else if (id_valid && m_ready()) begin
      m_v   <= 1'b1;
      m_a   <= resolve(id_rs1, id_rs1_data);
      m_rs2 <= resolve(id_rs2, id_rs2_data);
      m_b   <= id_use_imm ? id_imm : resolve(id_rs2, id_rs2_data);
      m_op  <= id_op; m_rd <= id_rd; m_pc <= id_pc;
    end else if (ex_ready) begin
      m_v <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("m_ex_valid", {31'b0, ex_valid}, {31'b0, m_v});
    chk("m_id_ready", {31'b0, id_ready}, {31'b0, m_ready()});
    chk("m_ex_a", ex_a, m_a);
    chk("m_ex_b", ex_b, m_b);
    chk("m_ex_rs2_val", ex_rs2_val, m_rs2);
    chk("m_ex_op", {27'b0, ex_op}, {27'b0, m_op});
    chk("m_ex_rd", {27'b0, ex_rd}, {27'b0, m_rd});
    chk("m_ex_pc", ex_pc, m_pc);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [4:0] op, input logic [4:0] rs1, input logic [31:0] d1,
                       input logic [4:0] rs2, input logic [31:0] d2, input logic [4:0] rd,
                       input logic [31:0] pc);
    id_valid = 1'b1; id_op = op; id_rs1 = rs1; id_rs1_data = d1;
    id_rs2 = rs2; id_rs2_data = d2; id_rd = rd; id_pc = pc;
  endtask

  initial begin
    step(); step();
    rst_n = 1'b1;
    chk("reset_valid", {31'b0, ex_valid}, 32'h0);
    chk("reset_pc", ex_pc, 32'h0);
    // 1: MEM beats WB beats regfile
    instr(5'd3, 5'd5, 32'h11, 5'd6, 32'h66, 5'd9, 32'h100);
    mem_fwd_we = 1'b1; mem_fwd_rd = 5'd5; mem_fwd_data = 32'h22;
    wb_fwd_we = 1'b1; wb_fwd_rd = 5'd5; wb_fwd_data = 32'h33;
    step();
    chk("t1_a_mem", ex_a, 32'h22);
    chk("t1_b_rf", ex_b, 32'h66);
    chk("t1_valid", {31'b0, ex_valid}, 32'h1);
    mem_fwd_we = 1'b0;
    step();
    chk("t1_a_wb", ex_a, 32'h33);
    // 2: x0 never forwards; immediate select keeps rs2 for store data
    mem_fwd_we = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'hFF;
    wb_fwd_rd = 5'd0; wb_fwd_data = 32'hEE;
    instr(5'd4, 5'd0, 32'h55, 5'd8, 32'h88, 5'd1, 32'h104);
    id_use_imm = 1'b1; id_imm = 32'hFFFF_FFF0;
    step();
    chk("t2_a_zero", ex_a, 32'h0);
    chk("t2_b_imm", ex_b, 32'hFFFF_FFF0);
    chk("t2_rs2", ex_rs2_val, 32'h88);
    // 3: load-use on rs2 stalls, then resolves through WB
    id_use_imm = 1'b0;
    mem_fwd_we = 1'b1; mem_fwd_load = 1'b1; mem_fwd_rd = 5'd7; wb_fwd_we = 1'b0;
    instr(5'd5, 5'd1, 32'h10, 5'd7, 32'h77, 5'd2, 32'h108);
    #1;
    chk("t3_stall_ready", {31'b0, id_ready}, 32'h0);
    step();
    chk("t3_bubble", {31'b0, ex_valid}, 32'h0);
    mem_fwd_we = 1'b0; mem_fwd_load = 1'b0;
    wb_fwd_we = 1'b1; wb_fwd_rd = 5'd7; wb_fwd_data = 32'hABCD;
    step();
    chk("t3_b_wb", ex_b, 32'hABCD);
    chk("t3_valid", {31'b0, ex_valid}, 32'h1);
    wb_fwd_we = 1'b0;
    mem_fwd_we = 1'b1; mem_fwd_load = 1'b1; mem_fwd_rd = 5'd7;
    id_use_imm = 1'b1; id_imm = 32'h123; id_pc = 32'h10C;
    #1;
    chk("t3_imm_no_stall", {31'b0, id_ready}, 32'h1);
    step();
    chk("t3_imm_b", ex_b, 32'h123);
    mem_fwd_we = 1'b0; mem_fwd_load = 1'b0; id_use_imm = 1'b0;
    // 4: execute backpressure holds everything, then swap with no bubble
    ex_ready = 1'b0;
    instr(5'd10, 5'd2, 32'h1234, 5'd3, 32'h5678, 5'd4, 32'h200);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_ready_low", {31'b0, id_ready}, 32'h0);
      step();
      chk("t4_pc_held", ex_pc, 32'h10C);
      chk("t4_b_held", ex_b, 32'h123);
    end
    ex_ready = 1'b1;
    step();
    chk("t4_valid", {31'b0, ex_valid}, 32'h1);
    chk("t4_a_new", ex_a, 32'h1234);
    chk("t4_pc_new", ex_pc, 32'h200);
    // 5: flush during hold, then flush during accept
    ex_ready = 1'b0; id_valid = 1'b0; flush = 1'b1;
    step();
    chk("t5_flush_hold", {31'b0, ex_valid}, 32'h0);
    flush = 1'b0; ex_ready = 1'b1;
    instr(5'd11, 5'd9, 32'h99, 5'd0, 32'h0, 5'd5, 32'h300);
    step();
    chk("t5_loaded", {31'b0, ex_valid}, 32'h1);
    instr(5'd12, 5'd9, 32'hAA, 5'd0, 32'h0, 5'd6, 32'h304);
    flush = 1'b1;
    step();
    chk("t5_flush_accept", {31'b0, ex_valid}, 32'h0);
    chk("t5_pc_not_loaded", ex_pc, 32'h300);
    flush = 1'b0; id_valid = 1'b0;
    step();
    // 6: async reset during a hold
    instr(5'd13, 5'd9, 32'hBEEF, 5'd0, 32'h0, 5'd7, 32'h400);
    step();
    ex_ready = 1'b0;
    step();
    chk("t6_held", ex_a, 32'hBEEF);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {31'b0, ex_valid}, 32'h0);
    chk("t6_rst_a", ex_a, 32'h0);
    step();
    rst_n = 1'b1; ex_ready = 1'b1;
    instr(5'd14, 5'd9, 32'hCAFE, 5'd0, 32'h0, 5'd8, 32'h500);
    step();
    chk("t6_restart_a", ex_a, 32'hCAFE);
    chk("t6_restart_valid", {31'b0, ex_valid}, 32'h1);
    id_valid = 1'b0;
    step(); step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
